pps_write_buffer: RTL and testbench
===================================

# pps_write_buffer

Posted-store write buffer between the Execute stage and the SRAM data port. Execute produces a store's word address, aligned store data and byte-write enables in one cycle. This block queues them in a small FIFO so the pipeline does not wait on the slow asynchronous SRAM. It then drains entries one at a time through a req/ack handshake with a mandatory write-recovery cycle, and flags loads that hit a word still pending in the buffer.

## Interface
Parameters:
- DEPTH, 4, number of FIFO entries; power of two, at least 2
- PTR_W, 2, log2(DEPTH)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset; asynchronous, active-high
- wb_push  in  1  enqueue a store this cycle (Execute memop & memwr & pipeline advance)
- wb_addr  in  32  store byte address; only [31:2] is stored
- wb_data  in  32  lane-aligned store data
- wb_bwe  in  4  byte-write enables; bit i selects data[8i+7:8i]
- ld_addr  in  32  address of the load currently in Execute
- wb_full  out  1  count == DEPTH (combinational from registered count)
- wb_empty  out  1  count == 0 and state == IDLE
- ld_conflict  out  1  ld_addr[31:2] matches any valid entry (combinational)
- mem_req  out  1  write request to the SRAM controller (registered)
- mem_addr  out  30  word address of the write in flight (registered)
- mem_data  out  32  write data in flight (registered)
- mem_bwe  out  4  byte enables in flight (registered)
- mem_ack  in  1  one-cycle pulse; the write in flight has completed

## Operation
- FIFO storage per entry: {addr[31:2], data, bwe}. Head pointer, tail pointer and a (PTR_W+1)-bit count. Pointers wrap modulo DEPTH.
- Push: accepted when wb_push && count < DEPTH. Writes the tail slot and increments tail. A push while full is dropped silently; upstream must stall on wb_full.
- Pop: occurs only on mem_ack while in WRITE. Increments head.
- Push and pop in the same cycle: count is unchanged and both pointers advance. Acceptance of a push depends only on count before the edge, so a push at full with a simultaneous pop is still dropped.
- Entries whose bwe is 4'b0000 are pushed and drained like any other entry.
- The head entry stays valid in the FIFO until it is acked. The entry in flight is therefore always covered by ld_conflict.
- Drain FSM states: IDLE, WRITE, RECOVER.
  - IDLE: if count > 0, load the head into mem_addr/mem_data/mem_bwe, set mem_req=1 and go to WRITE. Otherwise stay in IDLE.
  - WRITE: hold mem_req=1 and the output registers stable. On mem_ack, pop, clear mem_req and go to RECOVER.
  - RECOVER: mem_req=0 for exactly one cycle (SRAM WE turnaround). If count > 0 after the pop, load the new head, set mem_req=1 and go to WRITE. Otherwise go to IDLE.
- mem_ack outside WRITE is ignored.
- ld_conflict: the Execute-side hazard logic stalls the load while it is 1. No data forwarding is done.

## Timing
- Reset values (asynchronous): count=0, head=0, tail=0, state=IDLE, mem_req=0, mem_addr=0, mem_data=0, mem_bwe=0. Consequently wb_full=0, wb_empty=1, ld_conflict=0.
- Reset asserted mid-write drops mem_req immediately and discards all queued entries.
- Latency: a push at edge N with the buffer empty and idle gives count=1 after N. mem_req is high after edge N+1.
- Fastest drain: ack in the first WRITE cycle gives one entry per 2 cycles (WRITE, RECOVER).
- mem_addr/mem_data/mem_bwe change only on transitions into WRITE.
- wb_full deasserts the cycle after the edge at which the pop occurs.
- ld_conflict reflects the buffer contents as of the last edge. A push in the same cycle is not yet visible.

## Test plan
- Single store: reset, push addr=0x0000_1004, data=0xDEAD_BEEF, bwe=4'b1111 at edge 1 -> mem_req=1 after edge 2 with mem_addr=0x401; ack -> mem_req=0 for one cycle, then IDLE, wb_empty=1.
- Fill and stall: push 5 stores back-to-back with mem_ack held 0 -> wb_full=1 after the 4th push; the 5th is dropped; draining with acks yields exactly the first 4, in order.
- Back-to-back drain: 3 entries queued, ack every WRITE cycle -> mem_req pattern 1,0,1,0,1,0 and the addresses match push order.
- Simultaneous push/pop at count=1: the ack edge coincides with a push -> count stays 1 and the new entry is issued after RECOVER.
- Load hazard: pending store to 0x2008, ld_addr=0x200B -> ld_conflict=1; ld_addr=0x200C -> 0; after the ack -> 0.
- Reset mid-WRITE with 2 entries queued: mem_req falls asynchronously; after release, wb_empty=1 and no further mem_req.

Source files
------------

// File: rtl/pps_write_buffer.sv
// Posted-store write buffer: queues Execute-stage stores and drains them to the
// SRAM one at a time with a req/ack handshake and a write-recovery cycle.
module pps_write_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_push,
    input  logic [31:0] wb_addr,
    input  logic [31:0] wb_data,
    input  logic [3:0]  wb_bwe,
    input  logic [31:0] ld_addr,
    output logic        wb_full,
    output logic        wb_empty,
    output logic        ld_conflict,
    output logic        mem_req,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_data,
    output logic [3:0]  mem_bwe,
    input  logic        mem_ack
);
    typedef enum logic [1:0] {IDLE, WRITE, RECOVER} state_t;

    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = 1;

    logic [29:0] addr_mem [DEPTH];
    logic [31:0] data_mem [DEPTH];
    logic [3:0]  bwe_mem  [DEPTH];

    logic [PTR_W:0]   count_reg, count_next;
    logic [PTR_W-1:0] head_reg, tail_reg;
    state_t           state_reg;
    logic             mem_req_reg;
    logic [29:0]      mem_addr_reg;
    logic [31:0]      mem_data_reg;
    logic [3:0]       mem_bwe_reg;

    logic             push_ok, pop;
    logic [DEPTH-1:0] hit_vec;
    logic             unused_bits;

    // Acceptance looks only at the pre-edge count, so a pop cannot make room
    // for a push in the same cycle.
    assign push_ok = wb_push && (count_reg < CNT_FULL);
    assign pop     = (state_reg == WRITE) && mem_ack;

    always_comb begin
        count_next = count_reg;
        case ({push_ok, pop})
            2'b10:   count_next = count_reg + CNT_ONE;
            2'b01:   count_next = count_reg - CNT_ONE;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            addr_mem[tail_reg] <= wb_addr[31:2];
            data_mem[tail_reg] <= wb_data;
            bwe_mem[tail_reg]  <= wb_bwe;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg    <= '0;
            head_reg     <= '0;
            tail_reg     <= '0;
            state_reg    <= IDLE;
            mem_req_reg  <= 1'b0;
            mem_addr_reg <= '0;
            mem_data_reg <= '0;
            mem_bwe_reg  <= '0;
        end else begin
            count_reg <= count_next;
            if (push_ok) tail_reg <= tail_reg + PTR_ONE;
            if (pop)     head_reg <= head_reg + PTR_ONE;
            case (state_reg)
                IDLE, RECOVER: begin
                    if (count_reg != '0) begin
                        mem_addr_reg <= addr_mem[head_reg];
                        mem_data_reg <= data_mem[head_reg];
                        mem_bwe_reg  <= bwe_mem[head_reg];
                        mem_req_reg  <= 1'b1;
                        state_reg    <= WRITE;
                    end else begin
                        state_reg    <= IDLE;
                    end
                end
                WRITE: begin
                    if (mem_ack) begin
                        mem_req_reg <= 1'b0;
                        state_reg   <= RECOVER;
                    end
                end
                default: begin
                    mem_req_reg <= 1'b0;
                    state_reg   <= IDLE;
                end
            endcase
        end
    end

    // An entry is valid when its distance from head is below count; the head
    // stays valid while in flight so it is still covered here.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
        logic [PTR_W-1:0] offset;
        assign offset      = PTR_W'(gi) - head_reg;
        assign hit_vec[gi] = ({1'b0, offset} < count_reg) && (addr_mem[gi] == ld_addr[31:2]);
    end

    assign ld_conflict = |hit_vec;
    assign wb_full     = (count_reg == CNT_FULL);
    assign wb_empty    = (count_reg == '0) && (state_reg == IDLE);
    assign mem_req     = mem_req_reg;
    assign mem_addr    = mem_addr_reg;
    assign mem_data    = mem_data_reg;
    assign mem_bwe     = mem_bwe_reg;
    assign unused_bits = ^{wb_addr[1:0], ld_addr[1:0]};
endmodule

// File: tb/tb_pps_write_buffer.sv
// Bench for pps_write_buffer: directed scenarios plus random traffic checked
// against a queue-based model of the buffer and its drain timing.
module tb_pps_write_buffer;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_push = 1'b0;
    logic [31:0] wb_addr = '0, wb_data = '0, ld_addr = '0;
    logic [3:0]  wb_bwe = '0;
    logic        wb_full, wb_empty, ld_conflict, mem_req, mem_ack = 1'b0;
    logic [29:0] mem_addr;
    logic [31:0] mem_data;
    logic [3:0]  mem_bwe;

    int total = 0;
    int bad   = 0;

    pps_write_buffer #(.DEPTH(DEPTH), .PTR_W(2)) dut (
        .clk(clk), .rst(rst), .wb_push(wb_push), .wb_addr(wb_addr),
        .wb_data(wb_data), .wb_bwe(wb_bwe), .ld_addr(ld_addr),
        .wb_full(wb_full), .wb_empty(wb_empty), .ld_conflict(ld_conflict),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_bwe(mem_bwe), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [29:0] a;
        logic [31:0] d;
        logic [3:0]  b;
    } entry_t;

    // Model: pending stores in order, the one in flight, and whether the
    // previous cycle completed a write (forcing one idle request cycle).
    entry_t q[$];
    entry_t cur;
    bit     in_flight;
    bit     turnaround;

    task automatic model_reset();
        q.delete();
        cur        = '0;
        in_flight  = 0;
        turnaround = 0;
    endtask

    task automatic model_edge();
        bit accept;
        accept = wb_push && (q.size() < DEPTH);
        if (in_flight) begin
            if (mem_ack) begin
                void'(q.pop_front());
                in_flight  = 0;
                turnaround = 1;
            end
        end else begin
            turnaround = 0;
            if (q.size() > 0) begin
                cur       = q[0];
                in_flight = 1;
            end
        end
        if (accept) q.push_back({wb_addr[31:2], wb_data, wb_bwe});
    endtask

    function automatic bit model_conflict();
        foreach (q[i]) if (q[i].a == ld_addr[31:2]) return 1;
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".req"},      64'(mem_req),     64'(in_flight));
        chk({tag, ".addr"},     64'(mem_addr),    64'(cur.a));
        chk({tag, ".data"},     64'(mem_data),    64'(cur.d));
        chk({tag, ".bwe"},      64'(mem_bwe),     64'(cur.b));
        chk({tag, ".full"},     64'(wb_full),     64'(q.size() == DEPTH));
        chk({tag, ".empty"},    64'(wb_empty),    64'(q.size() == 0 && !in_flight && !turnaround));
        chk({tag, ".conflict"}, 64'(ld_conflict), 64'(model_conflict()));
        $display("%0t %s push=%b a=%h ack=%b ld=%h | req=%b maddr=%h full=%b empty=%b conf=%b",
                 $time, tag, wb_push, wb_addr, mem_ack, ld_addr, mem_req, mem_addr,
                 wb_full, wb_empty, ld_conflict);
    endtask

    // One clock: inputs applied at the falling edge, outputs checked at the next one.
    task automatic cyc(input string tag, input logic p, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b,
                       input logic k, input logic [31:0] l);
        wb_push = p; wb_addr = a; wb_data = d; wb_bwe = b; mem_ack = k; ld_addr = l;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic idle(input string tag, input logic k);
        cyc(tag, 1'b0, 32'h0, 32'h0, 4'h0, k, 32'h0);
    endtask

    initial begin
        int n_writes;
        model_reset();
        #12;
        check_all("reset");
        chk("reset.empty_const", 64'(wb_empty), 64'd1);
        @(negedge clk);
        rst = 1'b0;

        // Single store
        cyc("single.push", 1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0);
        chk("single.req_before", 64'(mem_req), 64'd0);
        idle("single.issue", 1'b0);
        chk("single.req", 64'(mem_req), 64'd1);
        chk("single.addr", 64'(mem_addr), 64'h401);
        idle("single.ack", 1'b1);
        chk("single.recover_req", 64'(mem_req), 64'd0);
        idle("single.idle", 1'b0);
        chk("single.empty", 64'(wb_empty), 64'd1);

        // Fill and stall; the fifth push is dropped
        for (int i = 0; i < 5; i++)
            cyc("fill.push", 1'b1, 32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i), 4'(i), 1'b0, 32'h0);
        chk("fill.full", 64'(wb_full), 64'd1);
        n_writes = 0;
        for (int i = 0; i < 10; i++) begin
            if (mem_req) n_writes++;
            idle("fill.drain", 1'b1);
        end
        chk("fill.nwrites", 64'(n_writes), 64'd4);
        chk("fill.empty", 64'(wb_empty), 64'd1);

        // Load hazard
        cyc("haz.push", 1'b1, 32'h2008, 32'h1234_5678, 4'h3, 1'b0, 32'h200B);
        chk("haz.hit", 64'(ld_conflict), 64'd1);
        cyc("haz.miss", 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h200C);
        chk("haz.miss_const", 64'(ld_conflict), 64'd0);
        cyc("haz.ack", 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h200B);
        chk("haz.after_ack", 64'(ld_conflict), 64'd0);
        idle("haz.idle", 1'b0);

        // Push coinciding with the pop at count=1
        cyc("pp.push", 1'b1, 32'h3000, 32'h0, 4'h0, 1'b0, 32'h0);
        idle("pp.issue", 1'b0);
        cyc("pp.both", 1'b1, 32'h3004, 32'hCAFE_F00D, 4'h5, 1'b1, 32'h0);
        chk("pp.not_empty", 64'(wb_empty), 64'd0);
        idle("pp.reissue", 1'b0);
        chk("pp.addr", 64'(mem_addr), 64'hC01);
        chk("pp.req", 64'(mem_req), 64'd1);
        idle("pp.ack", 1'b1);
        idle("pp.idle", 1'b0);

        // Reset in the middle of a write with two entries queued
        cyc("rst.push0", 1'b1, 32'h4000, 32'h1, 4'hF, 1'b0, 32'h0);
        cyc("rst.push1", 1'b1, 32'h4004, 32'h2, 4'hF, 1'b0, 32'h0);
        idle("rst.write", 1'b0);
        chk("rst.req_before", 64'(mem_req), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst.req_async", 64'(mem_req), 64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) idle("rst.after", 1'b0);
        chk("rst.empty", 64'(wb_empty), 64'd1);

        // Random traffic over a small address window so hazards occur
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a, l;
            a = {30'h800 + 30'($urandom_range(0, 7)), 2'($urandom)};
            l = {30'h800 + 30'($urandom_range(0, 7)), 2'($urandom)};
            cyc("rand", 1'($urandom_range(0, 99) < 45), a, $urandom, 4'($urandom),
                1'($urandom_range(0, 99) < 40), l);
        end
        for (int i = 0; i < 20; i++) idle("flush", 1'b1);
        chk("flush.empty", 64'(wb_empty), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
